// File: rtl/i2c_target_mem.sv
// I2C target with a small byte register file. SCL/SDA are oversampled on the
// core clock; SDA is only ever pulled low and SCL is never stretched.
module i2c_target_mem #(
   parameter logic [6:0] TARGET_ADDR = 7'h50,
   parameter int         MEM_DEPTH   = 16,
   parameter int         SYNC_STAGES = 2
) (
   input  logic                         i2c_core_clk_i,
   input  logic                         preset_n_i,
   input  logic                         scl_i,
   input  logic                         sda_i,
   output logic                         sda_oe_o,
   output logic                         busy_o,
   output logic                         wr_valid_o,
   output logic [$clog2(MEM_DEPTH)-1:0] wr_addr_o,
   output logic [7:0]                   wr_data_o
);
   localparam int AW = $clog2(MEM_DEPTH);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RMACK, IDLE_WAIT
   } state_t;

   state_t                 state_reg, state_next;
   logic [SYNC_STAGES-1:0] scl_sync_reg, sda_sync_reg;
   logic                   scl_prev_reg, sda_prev_reg;
   logic [3:0]             bit_cnt_reg, bit_cnt_next;
   logic [6:0]             shift_reg, shift_next;
   logic [7:0]             tx_reg, tx_next;
   logic [AW-1:0]          ptr_reg, ptr_next;
   logic                   rw_reg, rw_next;
   logic                   sda_oe_reg, sda_oe_next;
   logic                   busy_reg, busy_next;
   logic                   wr_valid_reg, wr_valid_next;
   logic [AW-1:0]          wr_addr_reg, wr_addr_next;
   logic [7:0]             wr_data_reg, wr_data_next;
   logic [7:0]             mem_reg [MEM_DEPTH];

   logic       scl_s, sda_s;
   logic       scl_rise, scl_fall, start_det, stop_det;
   logic [7:0] byte_in, rd_byte;

   assign scl_s     = scl_sync_reg[SYNC_STAGES-1];
   assign sda_s     = sda_sync_reg[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_prev_reg;
   assign scl_fall  = ~scl_s & scl_prev_reg;
   assign start_det = scl_s & scl_prev_reg & sda_prev_reg & ~sda_s;
   assign stop_det  = scl_s & scl_prev_reg & ~sda_prev_reg & sda_s;
   assign byte_in   = {shift_reg, sda_s};
   assign rd_byte   = mem_reg[ptr_reg];

   // Synchronisers reset to the idle-high bus level so release of reset never looks like an edge.
   always_ff @(posedge i2c_core_clk_i or negedge preset_n_i) begin
      if (!preset_n_i) begin
         scl_sync_reg <= '1;
         sda_sync_reg <= '1;
         scl_prev_reg <= 1'b1;
         sda_prev_reg <= 1'b1;
      end else begin
         scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], scl_i};
         sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], sda_i};
         scl_prev_reg <= scl_s;
         sda_prev_reg <= sda_s;
      end
   end

   always_ff @(posedge i2c_core_clk_i or negedge preset_n_i) begin
      if (!preset_n_i) begin
         state_reg    <= IDLE;
         bit_cnt_reg  <= '0;
         shift_reg    <= '0;
         tx_reg       <= '0;
         ptr_reg      <= '0;
         rw_reg       <= 1'b0;
         sda_oe_reg   <= 1'b0;
         busy_reg     <= 1'b0;
         wr_valid_reg <= 1'b0;
         wr_addr_reg  <= '0;
         wr_data_reg  <= '0;
         for (int i = 0; i < MEM_DEPTH; i++) mem_reg[i] <= 8'h00;
      end else begin
         state_reg    <= state_next;
         bit_cnt_reg  <= bit_cnt_next;
         shift_reg    <= shift_next;
         tx_reg       <= tx_next;
         ptr_reg      <= ptr_next;
         rw_reg       <= rw_next;
         sda_oe_reg   <= sda_oe_next;
         busy_reg     <= busy_next;
         wr_valid_reg <= wr_valid_next;
         wr_addr_reg  <= wr_addr_next;
         wr_data_reg  <= wr_data_next;
         if (wr_valid_next) mem_reg[wr_addr_next] <= wr_data_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      bit_cnt_next  = bit_cnt_reg;
      shift_next    = shift_reg;
      tx_next       = tx_reg;
      ptr_next      = ptr_reg;
      rw_next       = rw_reg;
      sda_oe_next   = sda_oe_reg;
      busy_next     = busy_reg;
      wr_valid_next = 1'b0;
      wr_addr_next  = wr_addr_reg;
      wr_data_next  = wr_data_reg;

      if (start_det) begin
         state_next   = ADDR;
         bit_cnt_next = '0;
         busy_next    = 1'b1;
         sda_oe_next  = 1'b0;
      end else if (stop_det) begin
         state_next   = IDLE;
         bit_cnt_next = '0;
         busy_next    = 1'b0;
         sda_oe_next  = 1'b0;
      end else begin
         case (state_reg)
            ADDR, REG, WDATA: begin
               if (scl_rise) begin
                  shift_next   = byte_in[6:0];
                  bit_cnt_next = bit_cnt_reg + 4'd1;
                  if (bit_cnt_reg == 4'd7) begin
                     bit_cnt_next = '0;
                     if (state_reg == ADDR) begin
                        if (byte_in[7:1] == TARGET_ADDR) begin
                           rw_next    = byte_in[0];
                           state_next = ADDR_ACK;
                        end else begin
                           state_next = IDLE;
                        end
                     end else if (state_reg == REG) begin
                        ptr_next   = byte_in[AW-1:0];
                        state_next = REG_ACK;
                     end else begin
                        wr_valid_next = 1'b1;
                        wr_addr_next  = ptr_reg;
                        wr_data_next  = byte_in;
                        ptr_next      = ptr_reg + 1'b1;
                        state_next    = WDATA_ACK;
                     end
                  end
               end
            end
            // bit_cnt_reg doubles as the ACK phase: 0 = before ACK, 1 = ACK driven.
            ADDR_ACK, REG_ACK, WDATA_ACK: begin
               if (scl_fall) begin
                  if (bit_cnt_reg == 4'd0) begin
                     sda_oe_next  = 1'b1;
                     bit_cnt_next = 4'd1;
                  end else begin
                     sda_oe_next  = 1'b0;
                     bit_cnt_next = '0;
                     if (state_reg != ADDR_ACK) begin
                        state_next = WDATA;
                     end else if (!rw_reg) begin
                        state_next = REG;
                     end else begin
                        sda_oe_next  = ~rd_byte[7];
                        tx_next      = {rd_byte[6:0], 1'b0};
                        bit_cnt_next = 4'd1;
                        state_next   = RDATA;
                     end
                  end
               end
            end
            RDATA: begin
               if (scl_fall) begin
                  if (bit_cnt_reg == 4'd0) begin
                     sda_oe_next  = ~rd_byte[7];
                     tx_next      = {rd_byte[6:0], 1'b0};
                     bit_cnt_next = 4'd1;
                  end else if (bit_cnt_reg < 4'd8) begin
                     sda_oe_next  = ~tx_reg[7];
                     tx_next      = {tx_reg[6:0], 1'b0};
                     bit_cnt_next = bit_cnt_reg + 4'd1;
                     if (bit_cnt_reg == 4'd7) ptr_next = ptr_reg + 1'b1;
                  end else begin
                     sda_oe_next  = 1'b0;
                     bit_cnt_next = '0;
                     state_next   = RMACK;
                  end
               end
            end
            RMACK: begin
               if (scl_rise) state_next = sda_s ? IDLE_WAIT : RDATA;
            end
            default: ;
         endcase
      end
   end

   assign sda_oe_o   = sda_oe_reg;
   assign busy_o     = busy_reg;
   assign wr_valid_o = wr_valid_reg;
   assign wr_addr_o  = wr_addr_reg;
   assign wr_data_o  = wr_data_reg;
endmodule

// File: tb/tb_i2c_target_mem.sv
// Scoreboard bench for i2c_target_mem: a bit-banged master queues the expected
// SDA pull per SCL clock and each expected write; monitors pop and compare.
module tb_i2c_target_mem;
   localparam int HALF = 10;

   logic       clk = 1'b0;
   logic       preset_n = 1'b0;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       scl_i, sda_i;
   logic       sda_oe_o, busy_o, wr_valid_o;
   logic [3:0] wr_addr_o;
   logic [7:0] wr_data_o;

   int total_cnt = 0;
   int pass_cnt  = 0;

   logic        bus_q[$];
   logic [11:0] wr_q[$];

   assign scl_i = scl_m;
   assign sda_i = sda_m & ~sda_oe_o;

   always #5 clk = ~clk;

   i2c_target_mem dut (
      .i2c_core_clk_i(clk),
      .preset_n_i(preset_n),
      .scl_i(scl_i),
      .sda_i(sda_i),
      .sda_oe_o(sda_oe_o),
      .busy_o(busy_o),
      .wr_valid_o(wr_valid_o),
      .wr_addr_o(wr_addr_o),
      .wr_data_o(wr_data_o)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // SCL is low on entry; drive data, then one full SCL clock.
   task automatic send_bit(input logic b, input logic exp_oe);
      sda_m = b;
      clks(HALF / 2);
      bus_q.push_back(exp_oe);
      scl_m = 1'b1;
      clks(HALF);
      scl_m = 1'b0;
      clks(HALF / 2);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic ack_exp);
      for (int i = 7; i >= 0; i--) send_bit(d[i], 1'b0);
      send_bit(1'b1, ack_exp);
   endtask

   task automatic recv_byte(input logic [7:0] exp_byte, input logic master_nack);
      for (int i = 7; i >= 0; i--) send_bit(1'b1, ~exp_byte[i]);
      send_bit(master_nack, 1'b0);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1;
      clks(HALF);
      sda_m = 1'b0;
      clks(HALF);
      scl_m = 1'b0;
      clks(HALF / 2);
   endtask

   task automatic i2c_rep_start();
      sda_m = 1'b1;
      clks(HALF / 2);
      bus_q.push_back(1'b0);
      scl_m = 1'b1;
      clks(HALF);
      sda_m = 1'b0;
      clks(HALF);
      scl_m = 1'b0;
      clks(HALF / 2);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0;
      clks(HALF / 2);
      bus_q.push_back(1'b0);
      scl_m = 1'b1;
      clks(HALF);
      sda_m = 1'b1;
      clks(HALF);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_sda_oe"}, sda_oe_o, 0);
      check({tag, "_busy"}, busy_o, 0);
      check({tag, "_wr_valid"}, wr_valid_o, 0);
      check({tag, "_wr_addr"}, wr_addr_o, 0);
      check({tag, "_wr_data"}, wr_data_o, 0);
   endtask

   // Target SDA pull, sampled mid SCL-high.
   initial begin
      forever begin
         @(posedge scl_m);
         repeat (5) @(negedge clk);
         if (bus_q.size() == 0) begin
            total_cnt++;
            $display("FAIL bus_oe: got %0b expected no clock queued at %0t", sda_oe_o, $time);
         end else begin
            check("bus_oe", sda_oe_o, bus_q.pop_front());
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (wr_valid_o) begin
            if (wr_q.size() == 0) begin
               total_cnt++;
               $display("FAIL wr_valid: got addr %0h data %0h expected no write at %0t",
                        wr_addr_o, wr_data_o, $time);
            end else begin
               logic [11:0] e;
               e = wr_q.pop_front();
               check("wr_addr", wr_addr_o, e[11:8]);
               check("wr_data", wr_data_o, e[7:0]);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clks(3);
      check_reset_outputs("rst_in");
      preset_n = 1'b1;
      clks(5);
      check_reset_outputs("rst_out");

      // Write 0x11, 0x22 starting at register 3.
      wr_q.push_back({4'd3, 8'h11});
      wr_q.push_back({4'd4, 8'h22});
      i2c_start();
      check("busy_after_start", busy_o, 1);
      send_byte(8'hA0, 1'b1);
      send_byte(8'h03, 1'b1);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      i2c_stop();
      check("busy_after_stop", busy_o, 0);
      $display("txn 1: write 11,22 at reg 3");

      // Read back two bytes from register 3 via repeated START.
      i2c_start();
      send_byte(8'hA0, 1'b1);
      send_byte(8'h03, 1'b1);
      i2c_rep_start();
      check("busy_rep_start", busy_o, 1);
      send_byte(8'hA1, 1'b1);
      recv_byte(8'h11, 1'b0);
      recv_byte(8'h22, 1'b1);
      check("sda_after_nack", sda_oe_o, 0);
      i2c_stop();
      check("busy_after_read", busy_o, 0);
      $display("txn 2: read 2 bytes from reg 3");

      // Wrong address: no ACK and nothing written.
      i2c_start();
      send_byte(8'hA2, 1'b0);
      send_byte(8'h05, 1'b0);
      send_byte(8'h77, 1'b0);
      check("busy_mismatch", busy_o, 1);
      i2c_stop();
      check("busy_after_mismatch", busy_o, 0);
      $display("txn 3: address 0x51 ignored");

      // Pointer wrap on write and on read.
      wr_q.push_back({4'd15, 8'hAA});
      wr_q.push_back({4'd0, 8'hBB});
      i2c_start();
      send_byte(8'hA0, 1'b1);
      send_byte(8'h0F, 1'b1);
      send_byte(8'hAA, 1'b1);
      send_byte(8'hBB, 1'b1);
      i2c_stop();
      i2c_start();
      send_byte(8'hA0, 1'b1);
      send_byte(8'h0F, 1'b1);
      i2c_rep_start();
      send_byte(8'hA1, 1'b1);
      recv_byte(8'hAA, 1'b0);
      recv_byte(8'hBB, 1'b1);
      i2c_stop();
      $display("txn 4: write/read wrap at reg 15");

      // STOP after 4 data bits: byte discarded, pointer stays at 7.
      i2c_start();
      send_byte(8'hA0, 1'b1);
      send_byte(8'h07, 1'b1);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      i2c_stop();
      check("busy_abort", busy_o, 0);
      check("sda_abort", sda_oe_o, 0);
      i2c_start();
      send_byte(8'hA1, 1'b1);
      recv_byte(8'h00, 1'b1);
      i2c_stop();
      $display("txn 5: aborted write, reg 7 still 00");

      // Asynchronous reset while the target pulls SDA for a 0 read bit.
      i2c_start();
      send_byte(8'hA0, 1'b1);
      send_byte(8'h03, 1'b1);
      i2c_rep_start();
      send_byte(8'hA1, 1'b1);
      sda_m = 1'b1;
      clks(HALF / 2);
      bus_q.push_back(1'b1);
      scl_m = 1'b1;
      clks(7);
      #2;
      preset_n = 1'b0;
      #1;
      check("async_release", sda_oe_o, 0);
      clks(3);
      check_reset_outputs("rst_mid");
      preset_n = 1'b1;
      clks(HALF);
      check_reset_outputs("rst_mid_out");
      i2c_start();
      send_byte(8'hA0, 1'b1);
      send_byte(8'h03, 1'b1);
      i2c_rep_start();
      send_byte(8'hA1, 1'b1);
      recv_byte(8'h00, 1'b1);
      i2c_stop();
      $display("txn 6: reset mid-read, reg 3 now 00");

      clks(20);
      check("bus_q_drained", bus_q.size(), 0);
      check("wr_q_drained", wr_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
